// File: rtl/wb_arbiter_2m.sv
// Two-master Wishbone classic arbiter sharing one slave: round-robin grant,
// bus lock for the whole CYC burst, and an ack watchdog that answers a hung slave with ERR.
module wb_arbiter_2m #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TCNT_W         = 11
) (
  input  logic        clk_50,
  input  logic        reset_n,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  input  logic [3:0]  m0_sel_i,
  input  logic        m0_we_i,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  input  logic [3:0]  m1_sel_i,
  input  logic        m1_we_i,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  output logic [3:0]  s_sel_o,
  output logic        s_we_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i,
  output logic [1:0]  gnt_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_t;

  localparam bit WD_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [TCNT_W-1:0] WD_LIMIT = WD_EN ? TCNT_W'(TIMEOUT_CYCLES - 1) : '0;

  state_t             state;
  logic               last_served;
  logic [TCNT_W-1:0]  wd_cnt;
  logic               abort;
  logic               own0;
  logic               own1;
  logic               cur_cyc;
  logic               cur_stb;
  logic               xfer_ok;
  logic               xfer_wait;
  logic               timeout;

  assign own0    = (state == OWN0);
  assign own1    = (state == OWN1);
  assign cur_cyc = own1 ? m1_cyc_i : m0_cyc_i;
  assign cur_stb = own1 ? m1_stb_i : m0_stb_i;

  // The owner's request passes straight through; an aborted transfer keeps STB low.
  always_comb begin
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    s_we_o  = 1'b0;
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    if (own0) begin
      s_adr_o = m0_adr_i;
      s_dat_o = m0_dat_i;
      s_sel_o = m0_sel_i;
      s_we_o  = m0_we_i;
      s_cyc_o = m0_cyc_i;
      s_stb_o = m0_stb_i & ~abort;
    end else if (own1) begin
      s_adr_o = m1_adr_i;
      s_dat_o = m1_dat_i;
      s_sel_o = m1_sel_i;
      s_we_o  = m1_we_i;
      s_cyc_o = m1_cyc_i;
      s_stb_o = m1_stb_i & ~abort;
    end
  end

  assign xfer_ok   = s_cyc_o & s_stb_o & s_ack_i;
  assign xfer_wait = s_cyc_o & s_stb_o & ~s_ack_i;
  assign timeout   = WD_EN & xfer_wait & (wd_cnt == WD_LIMIT);

  assign m0_ack_o = own0 & xfer_ok;
  assign m0_err_o = own0 & timeout;
  assign m0_dat_o = own0 ? s_dat_i : '0;
  assign m1_ack_o = own1 & xfer_ok;
  assign m1_err_o = own1 & timeout;
  assign m1_dat_o = own1 ? s_dat_i : '0;

  // On a tie in IDLE the master not served last wins; abort lasts until the owner drops STB.
  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      gnt_o       <= 2'b00;
      last_served <= 1'b1;
      wd_cnt      <= '0;
      abort       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          wd_cnt <= '0;
          abort  <= 1'b0;
          if (m0_cyc_i && (!m1_cyc_i || last_served)) begin
            state       <= OWN0;
            gnt_o       <= 2'b01;
            last_served <= 1'b0;
          end else if (m1_cyc_i) begin
            state       <= OWN1;
            gnt_o       <= 2'b10;
            last_served <= 1'b1;
          end
        end
        OWN0, OWN1: begin
          if (!cur_cyc) begin
            state  <= IDLE;
            gnt_o  <= 2'b00;
            wd_cnt <= '0;
            abort  <= 1'b0;
          end else if (timeout) begin
            wd_cnt <= '0;
            abort  <= 1'b1;
          end else begin
            if (xfer_wait && WD_EN)
              wd_cnt <= wd_cnt + TCNT_W'(1);
            else
              wd_cnt <= '0;
            if (!cur_stb)
              abort <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          gnt_o <= 2'b00;
        end
      endcase
    end
  end

endmodule
